// File: rtl/demux_router_3way_pkg.sv
// demux_router_3way_pkg: shared widths, destination count, select encodings and slot state type
package demux_router_3way_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 16;
  localparam int NUM_DEST = 3;
  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
  function automatic logic [1:0] sel_to_dest(input logic [1:0] sel);
    return sel == SEL_D1 ? 2'd1 : sel == SEL_D2 ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/demux_router_3way_out_slot.sv
// demux_out_slot: one-entry output slot (acc_i/data_i in, valid_o/data_o/ready_i out, can_take_o, cnt_o accept count)
module demux_out_slot #(
  parameter int DATA_W = demux_router_3way_pkg::DATA_W,
  parameter int CNT_W = demux_router_3way_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              can_take_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  cnt_o
);
  import demux_router_3way_pkg::*;
  slot_state_e state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = acc_i ? SLOT_FULL : (state_q == SLOT_FULL && ready_i) ? SLOT_EMPTY : state_q;
    data_d = acc_i ? data_i : data_q;
    cnt_d = cnt_q + CNT_W'(acc_i);
  end
  assign valid_o = state_q == SLOT_FULL;
  assign can_take_o = !valid_o || ready_i;
  assign data_o = data_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/demux_router_3way.sv
// demux_router_3way: routes in_valid/in_ready/in_data by in_sel to three one-entry slots out0..2 (valid/ready/data) with per-destination counters cnt0..2
module demux_router_3way #(
  parameter int DATA_W = demux_router_3way_pkg::DATA_W,
  parameter int CNT_W = demux_router_3way_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out2_valid,
  input  logic              out2_ready,
  output logic [DATA_W-1:0] out2_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2
);
  import demux_router_3way_pkg::*;
  logic [1:0] dest;
  logic acc;
  logic [NUM_DEST-1:0] rdy, vld, take;
  logic [DATA_W-1:0] dat [NUM_DEST];
  logic [CNT_W-1:0] cnt [NUM_DEST];
  assign dest = sel_to_dest(in_sel);
  assign rdy = {out2_ready, out1_ready, out0_ready};
  // gated by rst_n so the source sees no ready while the slots are held in reset
  assign in_ready = rst_n && take[dest];
  assign acc = in_valid && in_ready;
  for (genvar k = 0; k < NUM_DEST; k++) begin : g_slot
    demux_out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .acc_i(acc && dest == 2'(k)),
      .data_i(in_data),
      .ready_i(rdy[k]),
      .can_take_o(take[k]),
      .valid_o(vld[k]),
      .data_o(dat[k]),
      .cnt_o(cnt[k])
    );
  end
  assign {out2_valid, out1_valid, out0_valid} = vld;
  assign out0_data = dat[0];
  assign out1_data = dat[1];
  assign out2_data = dat[2];
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
endmodule
